// File: rtl/load_store_unit.sv
// Load/store memory-access stage: validates requests, runs a valid/ack data-bus
// handshake, places store bytes and extracts/extends load results.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] dmem_out,
    output logic        resp_valid,
    output logic        fault,
    output logic        stall
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NSTRB = XLEN / 8;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state;
    logic            lat_store;
    logic [2:0]      lat_f3;
    logic [1:0]      lat_lo;

    logic            req_bad_c;
    logic [XLEN-1:0] st_data_c;
    logic [NSTRB-1:0] st_strb_c;
    logic [7:0]      ld_byte_c;
    logic [15:0]     ld_half_c;
    logic [XLEN-1:0] ld_data_c;

    // Request legality (alignment and funct3) plus store lane placement
    always_comb begin
        req_bad_c = 1'b0;
        st_data_c = wdata;
        st_strb_c = '0;
        case (funct3)
            3'b000: begin
                st_data_c = {4{wdata[7:0]}};
                st_strb_c = NSTRB'(4'b0001 << addr[1:0]);
            end
            3'b001: begin
                req_bad_c = addr[0];
                st_data_c = {2{wdata[15:0]}};
                st_strb_c = addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                req_bad_c = (addr[1:0] != 2'b00);
                st_strb_c = 4'b1111;
            end
            3'b100:  req_bad_c = is_store;
            3'b101:  req_bad_c = is_store | addr[0];
            default: req_bad_c = 1'b1;
        endcase
        if (!is_store) begin
            st_strb_c = '0;
        end
    end

    // Load extraction from the latched byte offset
    always_comb begin
        ld_byte_c = 8'(mem_rdata >> {lat_lo, 3'b000});
        ld_half_c = lat_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b100:  ld_data_c = {24'd0, ld_byte_c};
            3'b101:  ld_data_c = {16'd0, ld_half_c};
            default: ld_data_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_store  <= 1'b0;
            lat_f3     <= 3'd0;
            lat_lo     <= 2'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            dmem_out   <= '0;
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            stall      <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad_c) begin
                            fault <= 1'b1;
                        end else begin
                            lat_store <= is_store;
                            lat_f3    <= funct3;
                            lat_lo    <= addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= st_data_c;
                            mem_wstrb <= st_strb_c;
                            stall     <= 1'b1;
                            req_ready <= 1'b0;
                            state     <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        if (!lat_store) begin
                            dmem_out <= ld_data_c;
                        end
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    stall     <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    stall     <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between execute and register-file write-back. Takes one load/store request per transaction from execute (address = ALU result, store data = second register operand) and runs a valid/ack handshake on the data-memory bus. Stores get byte-lane placement and byte strobes; loads get byte/halfword extraction and sign/zero extension. Load results go to the write-back mux as `dmem_out`, and `stall` freezes the upstream pipeline while a transaction is in flight.

## Interface
- No parameters; all datapaths 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: execute presents a memory op.
- `req_ready` out 1: unit accepts a request this cycle; high only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address.
- `wdata` in 32: store data, unaligned (in low bits).
- `mem_req` out 1: bus request; held until ack.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-placed store data.
- `mem_wstrb` out 4: byte strobes; 0000 for loads.
- `mem_ack` in 1: bus completion; may be high in the first `mem_req` cycle.
- `mem_rdata` in 32: read word; valid when `mem_ack` is high on a load.
- `dmem_out` out 32: extended load result; held until the next load completes.
- `resp_valid` out 1: one-cycle completion pulse (loads and stores).
- `fault` out 1: one-cycle pulse for misaligned access or illegal funct3.
- `stall` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, BUS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, check the request.
  - Fault if any of: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠00; illegal funct3 (load 011/110/111, store ≥011).
  - Fault case: `fault`=1 in the next cycle, no bus access, stay IDLE.
  - Otherwise: latch op, funct3, `addr[1:0]`, `mem_addr`, `mem_wdata`, `mem_wstrb`; go to BUS.
- **BUS**
  - `mem_req`=1.
  - `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` stay stable until `mem_ack` is sampled.
  - On `mem_ack`:
    - Load: register the extracted `mem_rdata` into `dmem_out`.
    - Either op: go to RESP.
  - No `mem_ack`: remain in BUS indefinitely (no timeout).
- **RESP**
  - `resp_valid`=1, `req_ready`=0.
  - Go to IDLE on the next edge.
- **Store placement**
  - SB: `mem_wdata` = `{4{wdata[7:0]}}`; `mem_wstrb` = 0001 << `addr[1:0]`.
  - SH: `mem_wdata` = `{2{wdata[15:0]}}`; `mem_wstrb` = 0011 (`addr[1]`=0) or 1100 (`addr[1]`=1).
  - SW: `mem_wdata` = `wdata`; `mem_wstrb` = 1111.
- **Load extraction** (byte/half selected by latched `addr[1:0]`)
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: `mem_rdata` unchanged.
- **Register behaviour**
  - Stores never modify `dmem_out`.
  - `req_valid` and request inputs are ignored outside IDLE.

## Timing
- Reset values (async, immediate): state IDLE; `mem_req` 0; `mem_we` 0; `mem_addr` 0; `mem_wdata` 0; `mem_wstrb` 0000; `dmem_out` 0; `resp_valid` 0; `fault` 0; `stall` 0; `req_ready` 1.
- Reset during BUS: `mem_req` drops asynchronously; the transaction is abandoned and no response is produced.
- Accept at edge E0 → `mem_req`=1 in cycle 1.
- `mem_ack` in cycle k (k≥1) → `resp_valid`/`dmem_out` valid in cycle k+1; IDLE again in cycle k+2.
- Minimum request-to-response latency: 2 cycles.
- Back-to-back throughput: one transaction per 3 cycles with zero-wait memory.
- Fault: `fault` high in cycle 1 only; `req_ready` stays high, so a new request is accepted in cycle 1.
- `stall` is a registered state decode and is high in every BUS and RESP cycle.
- `dmem_out` changes only on the edge that samples `mem_ack` for a load.

## Test plan
- **LW, zero-wait:** `addr`=0x100, `mem_rdata`=0xDEADBEEF, ack in the first BUS cycle → `mem_addr`=0x100, `mem_wstrb`=0000, `resp_valid` two cycles after accept, `dmem_out`=0xDEADBEEF.
- **LB/LBU, sign vs zero extend:** `addr`=0x103, `mem_rdata`=0x80112233 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SB/SH placement:**
  - SB, `addr`=0x202, `wdata`=0x000000A5 → `mem_wdata`=0xA5A5A5A5, `mem_wstrb`=0100, `mem_we`=1.
  - SH, `addr`=0x202, `wdata`=0x1234 → `mem_wstrb`=1100.
- **Wait states:** ack delayed 4 cycles → `mem_req` and all bus fields stable for 4 cycles; `stall` high throughout; `resp_valid` is a single-cycle pulse.
- **Faults:** LW at 0x102, SH at 0x301, load funct3=011 → each gives a one-cycle `fault`, no `mem_req`, `dmem_out` unchanged.
- **Reset in BUS:** assert `rst` mid-wait → `mem_req` 0 immediately, `resp_valid` never asserts, a new LW after reset completes normally.
